// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and helpers for the traffic light controller.
package traffic_light_ctrl_pkg;

  // Controller phases; the 3-bit encoding is visible to anyone probing state_q.
  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_PED    = 3'd3,
    ST_FLASH  = 3'd4,
    ST_EMERG  = 3'd5
  } state_e;

  // Width of an approach index; a single approach still needs one bit.
  function automatic int way_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Control inputs and lamp outputs of one junction controller.
interface traffic_light_ctrl_if #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = traffic_light_ctrl_pkg::way_w(NUM_WAYS)
);
  logic                tick_en;
  logic                ped_req;
  logic                emergency;
  logic                flash_mode;
  logic [NUM_WAYS-1:0] red;
  logic [NUM_WAYS-1:0] yellow;
  logic [NUM_WAYS-1:0] green;
  logic                ped_walk;
  logic [WAY_W-1:0]    active_way;

  // Junction top / test driver side.
  modport master (
    output tick_en, ped_req, emergency, flash_mode,
    input  red, yellow, green, ped_walk, active_way
  );

  // Controller side.
  modport slave (
    input  tick_en, ped_req, emergency, flash_mode,
    output red, yellow, green, ped_walk, active_way
  );
endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase counter: counts timebase ticks, flags the last tick of a phase.
module traffic_light_ctrl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             expire_o
);
  logic [CNT_W-1:0] cnt_q;

  assign expire_o = tick_en_i && (cnt_q == dur_i - 1'b1);

  // Restart on a phase change or on expiry (flash half-periods repeat in place).
  always_ff @(posedge clk) begin
    if (!reset)                   cnt_q <= '0;
    else if (clr_i || expire_o)   cnt_q <= '0;
    else if (tick_en_i)           cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller with pedestrian, emergency and
// night flashing modes. Lamp outputs are registered from next-state.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int NUM_WAYS     = 2,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 6,
  parameter int FLASH_TICKS  = 4,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  tl_if
);
  localparam int WAY_W = way_w(NUM_WAYS);

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                ped_q, ped_d;
  logic                flash_q, flash_d;
  logic [NUM_WAYS-1:0] red_q, red_d, yel_q, yel_d, grn_q, grn_d;
  logic                walk_q, walk_d;
  logic [CNT_W-1:0]    dur;
  logic                expire, clr;

  traffic_light_ctrl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick_en_i (tl_if.tick_en),
    .clr_i     (clr),
    .dur_i     (dur),
    .expire_o  (expire)
  );

  // Phase length for the current state (EMERG is untimed).
  always_comb begin
    dur = CNT_W'(1);
    case (state_q)
      ST_ALLRED: dur = CNT_W'(ALLRED_TICKS);
      ST_GREEN:  dur = CNT_W'(GREEN_TICKS);
      ST_YELLOW: dur = CNT_W'(YELLOW_TICKS);
      ST_PED:    dur = CNT_W'(PED_TICKS);
      ST_FLASH:  dur = CNT_W'(FLASH_TICKS);
      default:   ;
    endcase
  end

  // Next-state: emergency > flash > pedestrian > rotation.
  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    flash_d = flash_q;
    ped_d   = ped_q | (tl_if.ped_req && state_q != ST_PED);
    case (state_q)
      ST_ALLRED: begin
        if (tl_if.emergency)       state_d = ST_EMERG;
        else if (expire) begin
          if (tl_if.flash_mode)    state_d = ST_FLASH;
          else if (ped_q) begin
            state_d = ST_PED;
            ped_d   = 1'b0;
          end
          else                     state_d = ST_GREEN;
        end
      end
      ST_GREEN:  if (tl_if.emergency || expire) state_d = ST_YELLOW;
      ST_YELLOW: begin
        // Yellow always completes so drivers are never cut short.
        if (expire) begin
          state_d = ST_ALLRED;
          way_d   = (way_q == WAY_W'(NUM_WAYS-1)) ? '0 : way_q + 1'b1;
        end
      end
      ST_PED: begin
        if (tl_if.emergency)       state_d = ST_EMERG;
        else if (expire)           state_d = ST_ALLRED;
      end
      ST_FLASH: begin
        if (tl_if.emergency)       state_d = ST_EMERG;
        else if (!tl_if.flash_mode) state_d = ST_ALLRED;
        else if (expire)           flash_d = ~flash_q;
      end
      ST_EMERG:  if (!tl_if.emergency) state_d = ST_ALLRED;
      default:   state_d = ST_ALLRED;
    endcase
    // Flashing always restarts dark on the next entry.
    if (state_d != ST_FLASH) flash_d = 1'b0;
  end

  assign clr = (state_d != state_q);

  // Lamp decode of the next state, so lamps change on the same edge as state.
  always_comb begin
    red_d  = '1;
    yel_d  = '0;
    grn_d  = '0;
    walk_d = 1'b0;
    case (state_d)
      ST_GREEN: begin
        for (int i = 0; i < NUM_WAYS; i++)
          if (way_d == WAY_W'(i)) begin
            grn_d[i] = 1'b1;
            red_d[i] = 1'b0;
          end
      end
      ST_YELLOW: begin
        for (int i = 0; i < NUM_WAYS; i++)
          if (way_d == WAY_W'(i)) begin
            yel_d[i] = 1'b1;
            red_d[i] = 1'b0;
          end
      end
      ST_FLASH: begin
        red_d = '0;
        yel_d = {NUM_WAYS{flash_d}};
      end
      ST_PED:  walk_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched requests and registered lamps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ALLRED;
      way_q   <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      red_q   <= '1;
      yel_q   <= '0;
      grn_q   <= '0;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
      walk_q  <= walk_d;
    end
  end

  assign tl_if.red        = red_q;
  assign tl_if.yellow     = yel_q;
  assign tl_if.green      = grn_q;
  assign tl_if.ped_walk   = walk_q;
  assign tl_if.active_way = way_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: segment table on a 2-way build, hand-written
// slow-tick/reset and 3-way rotation sequences, lamp invariant every cycle.
module tb_traffic_light_ctrl;
  logic clk = 1'b0;
  logic reset, reset3;
  always #5 clk = ~clk;

  traffic_light_ctrl_if #(.NUM_WAYS(2)) bus2 ();
  traffic_light_ctrl_if #(.NUM_WAYS(3)) bus3 ();

  traffic_light_ctrl dut2 (.clk(clk), .reset(reset), .tl_if(bus2));
  traffic_light_ctrl #(.NUM_WAYS(3)) dut3 (.clk(clk), .reset(reset3), .tl_if(bus3));

  localparam int K_R = 0, K_G = 1, K_Y = 2, K_P = 3, K_F0 = 4, K_F1 = 5;

  typedef struct {
    logic [1:0] red, yel, grn;
    logic       walk;
    logic       way;
  } exp_t;
  typedef struct {
    logic rst, ped, em, fl;
    exp_t e;
    int   n;
  } seg_t;
  typedef struct {
    logic [2:0] red, yel, grn;
    logic [1:0] way;
  } exp3_t;

  exp_t  sb[$];
  exp3_t sb3[$];
  seg_t  tbl[$];
  int nvec = 0;
  int nerr = 0;

  // Expected lamps for a phase kind owned by approach w.
  function automatic exp_t mkexp(input int kind, input logic w);
    exp_t e;
    logic [1:0] oh;
    oh = w ? 2'b10 : 2'b01;
    e.red = 2'b11; e.yel = 2'b00; e.grn = 2'b00; e.walk = 1'b0; e.way = w;
    case (kind)
      K_G:  begin e.grn = oh; e.red = ~oh; end
      K_Y:  begin e.yel = oh; e.red = ~oh; end
      K_P:  e.walk = 1'b1;
      K_F0: e.red = 2'b00;
      K_F1: begin e.red = 2'b00; e.yel = 2'b11; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic add(input logic rst, ped, em, fl, input int kind, input logic w, input int n);
    seg_t s;
    s.rst = rst; s.ped = ped; s.em = em; s.fl = fl;
    s.e = mkexp(kind, w); s.n = n;
    tbl.push_back(s);
  endtask

  function automatic bit inv_ok(input logic [2:0] r, y, g, input int n);
    bit ok;
    int c;
    ok = $onehot0(g);
    if (r == 3'b000 && g == 3'b000) return ok;
    for (int i = 0; i < n; i++) begin
      c = int'(r[i]) + int'(y[i]) + int'(g[i]);
      if (c != 1) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk_inv();
    nvec += 2;
    if (!inv_ok({1'b0, bus2.red}, {1'b0, bus2.yellow}, {1'b0, bus2.green}, 2)) begin
      nerr++;
      $display("FAIL invariant2: r=%b y=%b g=%b", bus2.red, bus2.yellow, bus2.green);
    end
    if (!inv_ok(bus3.red, bus3.yellow, bus3.green, 3)) begin
      nerr++;
      $display("FAIL invariant3: r=%b y=%b g=%b", bus3.red, bus3.yellow, bus3.green);
    end
  endtask

  task automatic step(input logic rst, tk, ped, em, fl, input exp_t e, input string nm);
    exp_t want;
    reset = rst; bus2.tick_en = tk; bus2.ped_req = ped;
    bus2.emergency = em; bus2.flash_mode = fl;
    sb.push_back(e);
    @(posedge clk); #1;
    want = sb.pop_front();
    nvec++;
    if ({bus2.red, bus2.yellow, bus2.green, bus2.ped_walk, bus2.active_way} !==
        {want.red, want.yel, want.grn, want.walk, want.way}) begin
      nerr++;
      $display("FAIL %s: got r=%b y=%b g=%b walk=%b way=%0d, want r=%b y=%b g=%b walk=%b way=%0d",
               nm, bus2.red, bus2.yellow, bus2.green, bus2.ped_walk, bus2.active_way,
               want.red, want.yel, want.grn, want.walk, want.way);
    end
    chk_inv();
  endtask

  task automatic step3(input logic [2:0] r, y, g, input logic [1:0] w, input string nm);
    exp3_t e, want;
    e.red = r; e.yel = y; e.grn = g; e.way = w;
    sb3.push_back(e);
    @(posedge clk); #1;
    want = sb3.pop_front();
    nvec++;
    if ({bus3.red, bus3.yellow, bus3.green, bus3.active_way} !==
        {want.red, want.yel, want.grn, want.way}) begin
      nerr++;
      $display("FAIL %s: got r=%b y=%b g=%b way=%0d, want r=%b y=%b g=%b way=%0d",
               nm, bus3.red, bus3.yellow, bus3.green, bus3.active_way,
               want.red, want.yel, want.grn, want.way);
    end
    chk_inv();
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[k])
      for (int i = 0; i < tbl[k].n; i++)
        step(tbl[k].rst, 1'b1, tbl[k].ped, tbl[k].em, tbl[k].fl, tbl[k].e,
             $sformatf("%s_seg%0d_c%0d", tag, k, i));
    tbl.delete();
  endtask

  initial begin
    reset = 1'b0; reset3 = 1'b0;
    bus2.tick_en = 1'b1; bus2.ped_req = 1'b0; bus2.emergency = 1'b0; bus2.flash_mode = 1'b0;
    bus3.tick_en = 1'b1; bus3.ped_req = 1'b0; bus3.emergency = 1'b0; bus3.flash_mode = 1'b0;

    //  rst ped em fl kind  way n
    // reset and plain rotation
    add(0, 0, 0, 0, K_R, 0, 3);
    add(1, 0, 0, 0, K_R, 0, 1);
    add(1, 0, 0, 0, K_G, 0, 8);
    add(1, 0, 0, 0, K_Y, 0, 3);
    add(1, 0, 0, 0, K_R, 1, 2);
    add(1, 0, 0, 0, K_G, 1, 8);
    add(1, 0, 0, 0, K_Y, 1, 3);
    add(1, 0, 0, 0, K_R, 0, 2);
    // pedestrian pulse during way0 green
    add(1, 1, 0, 0, K_G, 0, 1);
    add(1, 0, 0, 0, K_G, 0, 7);
    add(1, 0, 0, 0, K_Y, 0, 3);
    add(1, 0, 0, 0, K_R, 1, 2);
    add(1, 0, 0, 0, K_P, 1, 6);
    add(1, 0, 0, 0, K_R, 1, 2);
    // emergency on 5th green clock of way1
    add(1, 0, 0, 0, K_G, 1, 4);
    add(1, 0, 1, 0, K_Y, 1, 3);
    add(1, 0, 1, 0, K_R, 0, 10);
    add(1, 0, 0, 0, K_R, 0, 2);
    add(1, 0, 0, 0, K_G, 0, 8);
    add(1, 0, 0, 0, K_Y, 0, 3);
    // night flash, then emergency over flash, then resume
    add(1, 0, 0, 1, K_R, 1, 2);
    add(1, 0, 0, 1, K_F0, 1, 4);
    add(1, 0, 0, 1, K_F1, 1, 4);
    add(1, 0, 0, 1, K_F0, 1, 4);
    add(1, 0, 1, 1, K_R, 1, 3);
    add(1, 0, 0, 0, K_R, 1, 2);
    add(1, 0, 0, 0, K_G, 1, 8);
    add(1, 0, 0, 0, K_Y, 1, 3);
    add(1, 0, 0, 0, K_R, 0, 2);
    add(1, 0, 0, 0, K_G, 0, 1);
    run_tbl("main");

    // 1-in-4 tick: green spans 32 clocks, yellow 12; ped latched, then reset mid-yellow
    for (int e = 0; e < 36; e++)
      step(1'b1, (e % 4) == 3, e == 5, 1'b0, 1'b0, mkexp((e < 31) ? K_G : K_Y, 1'b0),
           $sformatf("slow_c%0d", e));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkexp(K_R, 1'b0), "rst_mid_yellow");
    // pending request must be gone: no PED after the first yellow
    add(1, 0, 0, 0, K_R, 0, 1);
    add(1, 0, 0, 0, K_G, 0, 8);
    add(1, 0, 0, 0, K_Y, 0, 3);
    add(1, 0, 0, 0, K_R, 1, 2);
    add(1, 0, 0, 0, K_G, 1, 1);
    run_tbl("post_rst");

    // 3-way build: green rotates 001, 010, 100, 001
    reset3 = 1'b1;
    step3(3'b111, 3'b000, 3'b000, 2'd0, "w3_allred0");
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++)
        step3(~(3'b001 << w), 3'b000, 3'b001 << w, 2'(w), $sformatf("w3_g%0d_c%0d", w, i));
      for (int i = 0; i < 3; i++)
        step3(~(3'b001 << w), 3'b001 << w, 3'b000, 2'(w), $sformatf("w3_y%0d_c%0d", w, i));
      for (int i = 0; i < 2; i++)
        step3(3'b111, 3'b000, 3'b000, 2'((w + 1) % 3), $sformatf("w3_r%0d_c%0d", w, i));
    end
    step3(3'b110, 3'b000, 3'b001, 2'd0, "w3_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
